// File: rtl/fusa_pkg.sv
// Shared types and constants for the
// dual-core lockstep safety monitor.
package fusa_pkg;

   typedef enum logic [1:0] {
      DISABLED = 2'd0,
      SYNC     = 2'd1,
      MONITOR  = 2'd2,
      FAULT    = 2'd3
   } ls_state_e;

   localparam int FC_PC   = 0;
   localparam int FC_REG3 = 1;
   localparam int FC_MEM0 = 2;
   localparam int FC_WDOG = 3;

   localparam int DEBUG_W = 32;
   localparam int TAP_W   = 3 * DEBUG_W;

endpackage

// File: rtl/lockstep_delay_line.sv
// WIDTH x DELAY shift register that realigns
// the leading core's taps with the trailing core.
module lockstep_delay_line
   import fusa_pkg::*;
#(
   parameter int WIDTH = TAP_W,
   parameter int DELAY = 2
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             shift,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   if (DELAY == 0) begin : g_bypass
      assign q = d;
   end else begin : g_line
      logic [WIDTH-1:0] stage [DELAY];

      always_ff @(posedge clk) begin
         if (clear) begin
            for (int i = 0; i < DELAY; i++)
               stage[i] <= '0;
         end else if (shift) begin
            stage[0] <= d;
            for (int i = 1; i < DELAY; i++)
               stage[i] <= stage[i-1];
         end
      end

      assign q = stage[DELAY-1];
   end

endmodule

// File: rtl/lockstep_comparator.sv
// Delayed-lockstep comparator with sticky fault,
// saturating mismatch counter and PC watchdog.
module lockstep_comparator
   import fusa_pkg::*;
#(
   parameter int DELAY       = 2,
   parameter int THRESHOLD   = 1,
   parameter int WDOG_CYCLES = 64,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [DEBUG_W-1:0] a_pc,
   input  logic [DEBUG_W-1:0] a_reg3,
   input  logic [DEBUG_W-1:0] a_mem0,
   input  logic [DEBUG_W-1:0] b_pc,
   input  logic [DEBUG_W-1:0] b_reg3,
   input  logic [DEBUG_W-1:0] b_mem0,
   input  logic               clear_fault,
   output logic               fault,
   output logic [3:0]         fault_code,
   output logic [CNT_W-1:0]   mismatch_count,
   output logic [1:0]         state
);

   localparam int RUN_W = 8;
   localparam int WD_W  = $clog2(WDOG_CYCLES + 1);

   localparam logic [3:0] SYNC_LAST =
      4'((DELAY > 0) ? DELAY - 1 : 0);
   localparam logic [RUN_W-1:0] RUN_MAX =
      RUN_W'(THRESHOLD);
   localparam logic [WD_W-1:0] WD_MAX =
      WD_W'(WDOG_CYCLES);

   // With no lag there is nothing to prefill.
   localparam ls_state_e ARM =
      (DELAY == 0) ? MONITOR : SYNC;

   ls_state_e          state_q;
   ls_state_e          state_d;
   logic [3:0]         sync_cnt;
   logic [RUN_W-1:0]   run_cnt;
   logic [WD_W-1:0]    wd_cnt;
   logic [DEBUG_W-1:0] prev_pc;
   logic [TAP_W-1:0]   a_dly;
   logic               shift_en;
   logic               cmp_en;
   logic [2:0]         miss;
   logic               sample_mismatch;
   logic               pc_stuck;
   logic               trig_mm;
   logic               trig_wd;
   logic               trigger;

   lockstep_delay_line #(
      .WIDTH (TAP_W),
      .DELAY (DELAY)
   ) u_dly (
      .clk   (clk),
      .clear (reset),
      .shift (shift_en),
      .d     ({a_pc, a_reg3, a_mem0}),
      .q     (a_dly)
   );

   always_comb begin
      shift_en = (state_q != DISABLED);
      cmp_en   = (state_q == MONITOR);
   end

   always_comb begin
      miss = '0;
      if (cmp_en) begin
         miss[FC_PC]   =
            a_dly[3*DEBUG_W-1 -: DEBUG_W] != b_pc;
         miss[FC_REG3] =
            a_dly[2*DEBUG_W-1 -: DEBUG_W] != b_reg3;
         miss[FC_MEM0] =
            a_dly[DEBUG_W-1:0] != b_mem0;
      end
   end

   assign sample_mismatch = |miss;
   assign pc_stuck = cmp_en && (a_pc == prev_pc);

   assign trig_mm = sample_mismatch &&
      (run_cnt + RUN_W'(1) == RUN_MAX);
   assign trig_wd = pc_stuck &&
      (wd_cnt + WD_W'(1) == WD_MAX);
   assign trigger = trig_mm || trig_wd;

   always_ff @(posedge clk) begin
      if (reset)
         state_q <= DISABLED;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DISABLED:
            if (enable) state_d = ARM;
         SYNC:
            if (!enable)
               state_d = DISABLED;
            else if (sync_cnt == SYNC_LAST)
               state_d = MONITOR;
         MONITOR:
            if (trigger)
               state_d = FAULT;
            else if (!enable)
               state_d = DISABLED;
         FAULT:
            if (clear_fault) state_d = ARM;
         default:
            state_d = DISABLED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_cnt       <= '0;
         run_cnt        <= '0;
         wd_cnt         <= '0;
         prev_pc        <= '0;
         mismatch_count <= '0;
         fault          <= 1'b0;
         fault_code     <= '0;
      end else begin
         prev_pc <= a_pc;

         if (state_q == SYNC && state_d == SYNC)
            sync_cnt <= sync_cnt + 4'd1;
         else
            sync_cnt <= '0;

         // Counters only live while monitoring.
         if (state_d != MONITOR) begin
            run_cnt <= '0;
            wd_cnt  <= '0;
         end else begin
            run_cnt <= sample_mismatch ?
               run_cnt + RUN_W'(1) : '0;
            wd_cnt  <= pc_stuck ?
               wd_cnt + WD_W'(1) : '0;
         end

         if (sample_mismatch && mismatch_count != '1)
            mismatch_count <= mismatch_count + CNT_W'(1);

         if (state_q == FAULT && clear_fault) begin
            fault      <= 1'b0;
            fault_code <= '0;
         end else if (trigger) begin
            fault                     <= 1'b1;
            fault_code[FC_WDOG]       <= trig_wd;
            fault_code[FC_MEM0:FC_PC] <=
               trig_mm ? miss : 3'b000;
         end
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_lockstep_comparator.sv
// Scoreboard bench: three comparator configs
// driven by directed lockstep tap sequences.
module tb_lockstep_comparator;
   import fusa_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       reset;
   logic [2:0]       enable;
   logic [2:0]       clear_fault;
   logic [2:0][31:0] a_pc, a_reg3, a_mem0;
   logic [2:0][31:0] b_pc, b_reg3, b_mem0;
   logic [2:0]       fault;
   logic [2:0][3:0]  fault_code;
   logic [2:0][1:0]  state;
   logic [15:0]      cnt0;
   logic [3:0]       cnt1;
   logic [3:0]       cnt2;

   logic [2:0][95:0] h1, h2;
   logic [2:0][31:0] pcv;

   typedef struct {
      int         cyc;
      int         dut;
      string      name;
      logic       f;
      logic [3:0] code;
      int         cnt;
      logic [1:0] st;
   } exp_t;

   exp_t q[$];
   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   lockstep_comparator #(
      .DELAY(2), .THRESHOLD(1),
      .WDOG_CYCLES(64), .CNT_W(16)
   ) u0 (
      .clk(clk), .reset(reset[0]),
      .enable(enable[0]),
      .a_pc(a_pc[0]), .a_reg3(a_reg3[0]),
      .a_mem0(a_mem0[0]),
      .b_pc(b_pc[0]), .b_reg3(b_reg3[0]),
      .b_mem0(b_mem0[0]),
      .clear_fault(clear_fault[0]),
      .fault(fault[0]),
      .fault_code(fault_code[0]),
      .mismatch_count(cnt0),
      .state(state[0])
   );

   lockstep_comparator #(
      .DELAY(2), .THRESHOLD(3),
      .WDOG_CYCLES(8), .CNT_W(4)
   ) u1 (
      .clk(clk), .reset(reset[1]),
      .enable(enable[1]),
      .a_pc(a_pc[1]), .a_reg3(a_reg3[1]),
      .a_mem0(a_mem0[1]),
      .b_pc(b_pc[1]), .b_reg3(b_reg3[1]),
      .b_mem0(b_mem0[1]),
      .clear_fault(clear_fault[1]),
      .fault(fault[1]),
      .fault_code(fault_code[1]),
      .mismatch_count(cnt1),
      .state(state[1])
   );

   lockstep_comparator #(
      .DELAY(0), .THRESHOLD(255),
      .WDOG_CYCLES(64), .CNT_W(4)
   ) u2 (
      .clk(clk), .reset(reset[2]),
      .enable(enable[2]),
      .a_pc(a_pc[2]), .a_reg3(a_reg3[2]),
      .a_mem0(a_mem0[2]),
      .b_pc(b_pc[2]), .b_reg3(b_reg3[2]),
      .b_mem0(b_mem0[2]),
      .clear_fault(clear_fault[2]),
      .fault(fault[2]),
      .fault_code(fault_code[2]),
      .mismatch_count(cnt2),
      .state(state[2])
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      exp_t e;
      int   ac;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         if (e.dut == 0)      ac = int'(cnt0);
         else if (e.dut == 1) ac = int'(cnt1);
         else                 ac = int'(cnt2);
         checks++;
         if (e.cyc != cyc ||
             fault[e.dut] !== e.f ||
             fault_code[e.dut] !== e.code ||
             ac != e.cnt ||
             state[e.dut] !== e.st) begin
            errors++;
            $display({"FAIL %s dut%0d cyc %0d/%0d: ",
               "got f=%b code=%b cnt=%0d st=%0d ",
               "want f=%b code=%b cnt=%0d st=%0d"},
               e.name, e.dut, cyc, e.cyc,
               fault[e.dut], fault_code[e.dut],
               ac, state[e.dut],
               e.f, e.code, e.cnt, e.st);
         end
      end
   end

   task automatic chk(
      input int         d,
      input string      n,
      input logic       f,
      input logic [3:0] c,
      input int         k,
      input logic [1:0] s
   );
      exp_t e;
      e.cyc  = cyc;
      e.dut  = d;
      e.name = n;
      e.f    = f;
      e.code = c;
      e.cnt  = k;
      e.st   = s;
      q.push_back(e);
   endtask

   // x: bit0 flips b_pc, bit1 b_reg3, bit2 b_mem0
   task automatic step(
      input int          d,
      input logic [31:0] pc,
      input logic [2:0]  x
   );
      logic [95:0] a, b;
      a = {pc, pc * 32'd3, ~pc};
      b = (d == 2) ? a : h2[d];
      b ^= {31'd0, x[0], 31'd0, x[1],
            31'd0, x[2]};
      a_pc[d]   = a[95:64];
      a_reg3[d] = a[63:32];
      a_mem0[d] = a[31:0];
      b_pc[d]   = b[95:64];
      b_reg3[d] = b[63:32];
      b_mem0[d] = b[31:0];
      @(posedge clk);
      #1;
      h2[d] = h1[d];
      h1[d] = a;
   endtask

   task automatic run(
      input int         d,
      input logic [2:0] x
   );
      step(d, pcv[d], x);
      pcv[d] = pcv[d] + 32'd1;
   endtask

   initial begin
      reset       = '1;
      enable      = '0;
      clear_fault = '0;
      a_pc = '0; a_reg3 = '0; a_mem0 = '0;
      b_pc = '0; b_reg3 = '0; b_mem0 = '0;
      h1 = '0;
      h2 = '0;
      pcv[0] = 32'h100;
      pcv[1] = 32'h100;
      pcv[2] = 32'h200;
      #1;

      // Delay 2, threshold 1
      run(0, 3'b000);
      run(0, 3'b000);
      reset[0] = 1'b0;
      chk(0, "rst", 0, 4'h0, 0, 2'd0);
      enable[0] = 1'b1;
      run(0, 3'b000);
      chk(0, "sync_a", 0, 4'h0, 0, 2'd1);
      run(0, 3'b000);
      chk(0, "sync_b", 0, 4'h0, 0, 2'd1);
      run(0, 3'b000);
      chk(0, "monitor", 0, 4'h0, 0, 2'd2);
      for (int i = 0; i < 500; i++)
         run(0, 3'b000);
      chk(0, "clean", 0, 4'h0, 0, 2'd2);
      run(0, 3'b010);
      chk(0, "reg3", 1, 4'b0010, 1, 2'd3);
      run(0, 3'b001);
      chk(0, "sticky", 1, 4'b0010, 1, 2'd3);
      clear_fault[0] = 1'b1;
      run(0, 3'b001);
      clear_fault[0] = 1'b0;
      chk(0, "clear", 0, 4'h0, 1, 2'd1);
      run(0, 3'b001);
      chk(0, "resync", 0, 4'h0, 1, 2'd1);
      run(0, 3'b001);
      chk(0, "remon", 0, 4'h0, 1, 2'd2);
      run(0, 3'b001);
      chk(0, "refault", 1, 4'b0001, 2, 2'd3);
      reset[0] = 1'b1;
      run(0, 3'b000);
      reset[0]  = 1'b0;
      enable[0] = 1'b0;
      chk(0, "rst_fault", 0, 4'h0, 0, 2'd0);
      run(0, 3'b000);

      // Threshold 3, watchdog 8
      run(1, 3'b000);
      run(1, 3'b000);
      reset[1] = 1'b0;
      chk(1, "rst1", 0, 4'h0, 0, 2'd0);
      enable[1] = 1'b1;
      run(1, 3'b000);
      run(1, 3'b000);
      run(1, 3'b000);
      chk(1, "mon1", 0, 4'h0, 0, 2'd2);
      run(1, 3'b001);
      run(1, 3'b001);
      chk(1, "run2", 0, 4'h0, 2, 2'd2);
      run(1, 3'b000);
      run(1, 3'b001);
      run(1, 3'b001);
      chk(1, "run4", 0, 4'h0, 4, 2'd2);
      for (int i = 0; i < 8; i++)
         step(1, 32'h40, 3'b000);
      chk(1, "wd7", 0, 4'h0, 4, 2'd2);
      step(1, 32'h40, 3'b000);
      chk(1, "wdog", 1, 4'b1000, 4, 2'd3);
      step(1, 32'h40, 3'b000);

      // Delay 0, saturating 4-bit count
      run(2, 3'b000);
      run(2, 3'b000);
      reset[2] = 1'b0;
      chk(2, "rst2", 0, 4'h0, 0, 2'd0);
      enable[2] = 1'b1;
      run(2, 3'b000);
      chk(2, "direct", 0, 4'h0, 0, 2'd2);
      for (int i = 0; i < 20; i++) begin
         if (i == 15)
            chk(2, "sat15", 0, 4'h0, 15, 2'd2);
         run(2, 3'b100);
      end
      chk(2, "sat20", 0, 4'h0, 15, 2'd2);
      reset[2] = 1'b1;
      run(2, 3'b000);
      reset[2] = 1'b0;
      chk(2, "rst_sat", 0, 4'h0, 0, 2'd0);
      run(2, 3'b000);

      repeat (2) @(posedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL pending: %0d left, want 0",
            q.size());
      end
      $display("CHECKS %0d ERRORS %0d",
         checks, errors);
      $finish;
   end

endmodule
